// File: rtl/atomrvcore_ifu.sv
// Instruction fetch unit: holds the PC, issues single-outstanding imem requests,
// registers fetched words for decode and handles downstream-resolved redirects.
module atomrvcore_ifu #(
  parameter int                   DATAWIDTH = 32,
  parameter logic [DATAWIDTH-1:0] RESET_PC  = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 imem_req_o,
  output logic [DATAWIDTH-1:0] imem_addr_o,
  input  logic                 imem_gnt_i,
  input  logic                 imem_rvalid_i,
  input  logic [DATAWIDTH-1:0] imem_rdata_i,
  input  logic                 stall_i,
  input  logic                 BE_i,
  input  logic                 UJE_i,
  input  logic                 JALRE_i,
  input  logic [DATAWIDTH-1:0] immed_i,
  input  logic [DATAWIDTH-1:0] operand_A_i,
  input  logic [DATAWIDTH-1:0] ex_pc_i,
  output logic [DATAWIDTH-1:0] instr_o,
  output logic [DATAWIDTH-1:0] pc_o,
  output logic [DATAWIDTH-1:0] pc_plus4_o,
  output logic                 instr_valid_o,
  output logic                 misalign_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  localparam logic [DATAWIDTH-1:0] NOP       = DATAWIDTH'(32'h0000_0013);
  localparam logic [DATAWIDTH-1:0] FOUR      = DATAWIDTH'(4);
  localparam logic [DATAWIDTH-1:0] WORD_MASK = ~DATAWIDTH'(3);

  state_e               state_q, state_d;
  logic [DATAWIDTH-1:0] pc_q, pc_d;
  logic                 discard_q, discard_d;
  logic [DATAWIDTH-1:0] instr_q, instr_d;
  logic [DATAWIDTH-1:0] pc_out_q, pc_out_d;
  logic [DATAWIDTH-1:0] pc_plus4_q, pc_plus4_d;
  logic                 valid_q, valid_d;
  logic                 misalign_q, misalign_d;

  logic                 redirect;
  logic [DATAWIDTH-1:0] jalr_sum;
  logic [DATAWIDTH-1:0] jal_tgt;
  logic [DATAWIDTH-1:0] raw_tgt;
  logic                 out_free;
  logic                 hold_req;
  logic                 capture;

  always_comb begin
    redirect = JALRE_i | UJE_i | BE_i;
    jalr_sum = operand_A_i + immed_i;
    jal_tgt  = ex_pc_i + (immed_i << 1);
    raw_tgt  = JALRE_i ? (jalr_sum & ~DATAWIDTH'(1)) : jal_tgt;
  end

  // HOLD re-issues the fetch in the very cycle decode releases the stall
  assign out_free    = !stall_i || !valid_q;
  assign hold_req    = (state_q == S_HOLD) && !stall_i && !redirect;
  assign imem_req_o  = (state_q == S_REQ) || hold_req;
  assign imem_addr_o = pc_q & WORD_MASK;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    discard_d  = discard_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q & stall_i;
    misalign_d = 1'b0;
    capture    = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_gnt_i) begin
          state_d = S_WAIT;
          if (redirect) discard_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else if (redirect) begin
            state_d = S_REQ;
          end else if (out_free) begin
            capture = 1'b1;
            pc_d    = pc_q + FOUR;
            state_d = stall_i ? S_HOLD : S_REQ;
          end else begin
            // output still owned by decode: drop the word and refetch the same PC
            state_d = S_HOLD;
          end
        end else if (redirect) begin
          discard_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect || !stall_i) state_d = S_REQ;
        if (hold_req && imem_gnt_i) state_d = S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      instr_d    = imem_rdata_i;
      pc_out_d   = pc_q;
      pc_plus4_d = pc_q + FOUR;
      valid_d    = 1'b1;
    end

    if (redirect) begin
      pc_d       = raw_tgt & WORD_MASK;
      valid_d    = 1'b0;
      misalign_d = raw_tgt[1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC & WORD_MASK;
      discard_q  <= 1'b0;
      instr_q    <= NOP;
      pc_out_q   <= '0;
      pc_plus4_q <= FOUR;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      discard_q  <= discard_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign instr_o       = instr_q;
  assign pc_o          = pc_out_q;
  assign pc_plus4_o    = pc_plus4_q;
  assign instr_valid_o = valid_q;
  assign misalign_o    = misalign_q;

endmodule

// File: tb/tb_atomrvcore_ifu.sv
// Bench for atomrvcore_ifu: memory responder, directed redirect/stall/reset scenarios,
// and a scoreboard monitor comparing every word decode consumes.
module tb_atomrvcore_ifu;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i  = '0;
  logic        stall_i       = 1'b0;
  logic        BE_i          = 1'b0;
  logic        UJE_i         = 1'b0;
  logic        JALRE_i       = 1'b0;
  logic [31:0] immed_i       = '0;
  logic [31:0] operand_A_i   = '0;
  logic [31:0] ex_pc_i       = '0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        instr_valid_o;
  logic        misalign_o;

  int total = 0;
  int bad   = 0;

  logic gnt_en   = 1'b1;
  int   rv_delay = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb_q[$];

  atomrvcore_ifu #(.DATAWIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .stall_i(stall_i), .BE_i(BE_i), .UJE_i(UJE_i), .JALRE_i(JALRE_i),
    .immed_i(immed_i), .operand_A_i(operand_A_i), .ex_pc_i(ex_pc_i),
    .instr_o(instr_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
    .instr_valid_o(instr_valid_o), .misalign_o(misalign_o)
  );

  always #5 clk_i = ~clk_i;

  // memory image: two real instructions at 0 and 4, an address-tagged pattern elsewhere
  function automatic logic [31:0] word(input logic [31:0] addr);
    if (addr == 32'h0) return 32'h0050_0093;
    if (addr == 32'h4) return 32'h00A0_0113;
    return {addr[23:0], 8'h13};
  endfunction

  always_comb imem_gnt_i = imem_req_o && gnt_en;

  initial begin : mem_model
    logic        granted;
    logic [31:0] g_addr;
    logic [31:0] rv_addr;
    int          rv_cnt;
    rv_cnt  = -1;
    rv_addr = '0;
    forever begin
      @(negedge clk_i);
      granted = imem_req_o && imem_gnt_i && !rst_i;
      g_addr  = imem_addr_o;
      @(posedge clk_i);
      #1;
      if (granted) begin
        rv_addr = g_addr;
        rv_cnt  = rv_delay;
      end
      if (rv_cnt == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = word(rv_addr);
        rv_cnt        = -1;
      end else begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'hDEAD_BEEF;
        if (rv_cnt > 0) rv_cnt = rv_cnt - 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && instr_valid_o && !stall_i) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected actual pc=%h required=no word", pc_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_pc", pc_o, e.pc);
        check("sb_instr", instr_o, e.instr);
        check("sb_pc_plus4", pc_plus4_o, e.pc + 32'd4);
      end
    end
  end

  task automatic push(input logic [31:0] pc);
    sb_q.push_back('{pc: pc, instr: word(pc)});
  endtask

  task automatic sb_drain(input string name);
    check(name, sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i   = 1'b1;
    stall_i = 1'b0;
    BE_i    = 1'b0;
    UJE_i   = 1'b0;
    JALRE_i = 1'b0;
    gnt_en  = 1'b1;
    repeat (2) tick();
    rst_i = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // stream, stall/hold, resume
    rv_delay = 0;
    do_reset();
    check("rst_req", imem_req_o, 0);
    check("rst_instr", instr_o, 32'h13);
    check("rst_pc", pc_o, 0);
    check("rst_pc4", pc_plus4_o, 4);
    check("rst_valid", instr_valid_o, 0);
    check("rst_misalign", misalign_o, 0);
    push(0); push(4); push(8); push(32'hC);
    tick();
    check("c1_req", imem_req_o, 1);
    check("c1_addr", imem_addr_o, 0);
    tick(); check("c2_valid", instr_valid_o, 0);
    tick(); check("c3_valid", instr_valid_o, 1); check("c3_pc", pc_o, 0);
    tick(); check("c4_valid", instr_valid_o, 0);
    tick(); check("c5_valid", instr_valid_o, 1); check("c5_pc", pc_o, 4);
    tick(); stall_i = 1'b1;
    repeat (3) begin
      tick();
      check("hold_pc", pc_o, 8);
      check("hold_instr", instr_o, word(8));
      check("hold_req", imem_req_o, 0);
      check("hold_valid", instr_valid_o, 1);
    end
    tick(); stall_i = 1'b0; #1;
    check("resume_req", imem_req_o, 1);
    check("resume_addr", imem_addr_o, 32'hC);
    repeat (3) tick();
    sb_drain("drain_stream");

    // branch then two JALR redirects
    do_reset();
    push(0); push(8);
    repeat (3) tick();
    BE_i = 1'b1; ex_pc_i = 32'h10; immed_i = 32'hFFFF_FFFC;
    tick(); BE_i = 1'b0;
    check("be_valid", instr_valid_o, 0);
    check("be_addr", imem_addr_o, 32'h8);
    check("be_req", imem_req_o, 0);
    tick();
    check("be_req2", imem_req_o, 1);
    check("be_addr2", imem_addr_o, 32'h8);
    tick(); tick();
    check("be_tgt_valid", instr_valid_o, 1);
    check("be_tgt_pc", pc_o, 32'h8);
    push(32'h104);
    gnt_en = 1'b0; JALRE_i = 1'b1; operand_A_i = 32'h101; immed_i = 32'h3;
    tick(); JALRE_i = 1'b0;
    check("jalr_addr", imem_addr_o, 32'h104);
    check("jalr_req", imem_req_o, 1);
    check("jalr_misalign", misalign_o, 0);
    check("jalr_valid", instr_valid_o, 0);
    gnt_en = 1'b1;
    tick(); tick();
    check("jalr_tgt_pc", pc_o, 32'h104);
    push(32'h100);
    JALRE_i = 1'b1; operand_A_i = 32'h102; immed_i = 32'h0;
    tick(); JALRE_i = 1'b0;
    check("jalr_mis_pulse", misalign_o, 1);
    check("jalr_mis_addr", imem_addr_o, 32'h100);
    check("jalr_mis_valid", instr_valid_o, 0);
    tick();
    check("jalr_mis_clear", misalign_o, 0);
    check("jalr_mis_req", imem_req_o, 1);
    tick(); tick();
    check("jalr_mis_pc", pc_o, 32'h100);
    tick();
    sb_drain("drain_redirect");

    // JAL during a slow response, then wrap through 0xFFFFFFFC
    rv_delay = 3;
    do_reset();
    push(32'h30); push(32'hFFFF_FFFC); push(0);
    tick(); tick();
    UJE_i = 1'b1; ex_pc_i = 32'h20; immed_i = 32'h8;
    check("jal_wait_req", imem_req_o, 0);
    tick(); UJE_i = 1'b0; rv_delay = 0;
    check("jal_valid", instr_valid_o, 0);
    check("jal_addr", imem_addr_o, 32'h30);
    check("jal_req_held", imem_req_o, 0);
    repeat (3) tick();
    check("jal_req", imem_req_o, 1);
    check("jal_addr2", imem_addr_o, 32'h30);
    check("jal_late_dropped", instr_valid_o, 0);
    tick(); tick();
    check("jal_tgt_pc", pc_o, 32'h30);
    UJE_i = 1'b1; ex_pc_i = 32'h0; immed_i = 32'hFFFF_FFFE;
    tick(); UJE_i = 1'b0;
    check("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
    tick();
    check("wrap_req", imem_req_o, 1);
    tick(); tick();
    check("wrap_pc", pc_o, 32'hFFFF_FFFC);
    check("wrap_pc4", pc_plus4_o, 0);
    check("wrap_next_addr", imem_addr_o, 0);
    tick(); tick();
    check("wrap_zero_pc", pc_o, 0);
    tick();
    sb_drain("drain_jal");

    // reset while waiting; the stale response lands in IDLE
    rv_delay = 2;
    do_reset();
    push(0);
    tick(); tick();
    rst_i = 1'b1; #1;
    check("mid_rst_req", imem_req_o, 0);
    check("mid_rst_valid", instr_valid_o, 0);
    rv_delay = 0;
    tick(); tick();
    rst_i = 1'b0;
    check("rel_req", imem_req_o, 0);
    check("rel_instr", instr_o, 32'h13);
    check("rel_pc", pc_o, 0);
    check("rel_pc4", pc_plus4_o, 4);
    check("rel_valid", instr_valid_o, 0);
    check("rel_misalign", misalign_o, 0);
    tick();
    check("stale_valid", instr_valid_o, 0);
    check("refetch_req", imem_req_o, 1);
    check("refetch_addr", imem_addr_o, 0);
    tick(); check("refetch_wait_valid", instr_valid_o, 0);
    tick(); check("refetch_pc", pc_o, 0);
    tick();
    sb_drain("drain_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
